alu_muldiv_seq: RTL and testbench

ALU_MULDIV_SEQ -- requirements
Module: alu_muldiv_seq

---
 rtl/alu_muldiv_seq.sv | 154 +++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_seq.sv
// rtl/alu_muldiv_seq.sv - sequential 16x16 multiply / 16/16 divide driving an external shared ALU
module alu_muldiv_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        op_sel,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] res_hi,
  output logic [15:0] res_lo,
  output logic [3:0]  alu_op,
  output logic [15:0] alu_ina,
  output logic [15:0] alu_inb,
  output logic        alu_cin,
  input  logic [15:0] alu_out,
  input  logic        alu_cout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0010;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  // hi holds acc_hi (MUL) or rem (DIV); lo holds mplier or quo; opnd holds mcand or divisor
  logic [15:0] hi_q, hi_d;
  logic [15:0] lo_q, lo_d;
  logic [15:0] opnd_q, opnd_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [15:0] res_hi_q, res_hi_d;
  logic [15:0] res_lo_q, res_lo_d;
  logic        div_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      hi_q     <= 16'h0000;
      lo_q     <= 16'h0000;
      opnd_q   <= 16'h0000;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      res_hi_q <= 16'h0000;
      res_lo_q <= 16'h0000;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
    end
  end

  // ALU drive depends only on registered state so the external ALU sees a stable request
  always_comb begin
    alu_op  = ALU_ADD;
    alu_ina = 16'h0000;
    alu_inb = 16'h0000;
    alu_cin = 1'b0;
    case (state_q)
      S_MUL: begin
        alu_op  = ALU_ADD;
        alu_ina = hi_q;
        alu_inb = lo_q[0] ? opnd_q : 16'h0000;
        alu_cin = 1'b0;
      end
      S_DIV: begin
        alu_op  = ALU_SUB;
        alu_ina = {hi_q[14:0], lo_q[15]};
        alu_inb = opnd_q;
        alu_cin = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    // a bit shifted out of rem[15] means the 17-bit partial remainder always exceeds the divisor
    div_ok   = hi_q[15] | alu_cout;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op_sel && (b == 16'h0000)) begin
            done_d   = 1'b1;
            err_d    = 1'b1;
            res_hi_d = a;
            res_lo_d = 16'hFFFF;
          end else begin
            hi_d    = 16'h0000;
            lo_d    = a;
            opnd_d  = b;
            cnt_d   = 4'd0;
            busy_d  = 1'b1;
            state_d = op_sel ? S_DIV : S_MUL;
          end
        end
      end
      S_MUL: begin
        hi_d  = {alu_cout, alu_out[15:1]};
        lo_d  = {alu_out[0], lo_q[15:1]};
        cnt_d = cnt_q + 4'd1;
      end
      S_DIV: begin
        hi_d  = div_ok ? alu_out : {hi_q[14:0], lo_q[15]};
        lo_d  = {lo_q[14:0], div_ok};
        cnt_d = cnt_q + 4'd1;
      end
      default: state_d = S_IDLE;
    endcase

    if ((state_q != S_IDLE) && (cnt_q == 4'd15)) begin
      busy_d   = 1'b0;
      done_d   = 1'b1;
      err_d    = 1'b0;
      res_hi_d = hi_d;
      res_lo_d = lo_d;
      state_d  = S_IDLE;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign res_hi = res_hi_q;
  assign res_lo = res_lo_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb/tb_alu_muldiv_seq.sv - self-checking bench for alu_muldiv_seq with a behavioural ALU
module tb_alu_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst, start, op_sel;
  logic [15:0] a_i, b_i;
  logic        busy, done, err;
  logic [15:0] res_hi, res_lo;
  logic [3:0]  alu_op;
  logic [15:0] alu_ina, alu_inb, alu_out;
  logic        alu_cin, alu_cout;
  logic [16:0] alu_sum;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_muldiv_seq dut (
    .clk(clk), .rst(rst), .start(start), .op_sel(op_sel), .a(a_i), .b(b_i),
    .busy(busy), .done(done), .err(err), .res_hi(res_hi), .res_lo(res_lo),
    .alu_op(alu_op), .alu_ina(alu_ina), .alu_inb(alu_inb), .alu_cin(alu_cin),
    .alu_out(alu_out), .alu_cout(alu_cout)
  );

  // shared ALU: add, or subtract as ina + ~inb + cin
  always_comb begin
    if (alu_op == 4'b0010)
      alu_sum = {1'b0, alu_ina} + {1'b0, ~alu_inb} + {16'h0000, alu_cin};
    else
      alu_sum = {1'b0, alu_ina} + {1'b0, alu_inb} + {16'h0000, alu_cin};
  end
  assign alu_out  = alu_sum[15:0];
  assign alu_cout = alu_sum[16];

  typedef struct {
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] hi;
    logic [15:0] lo;
    logic        e;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model(input logic op, input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] hi, output logic [15:0] lo, output logic e);
    logic [31:0] p;
    if (op && b == 16'h0000) begin
      hi = a; lo = 16'hFFFF; e = 1'b1;
    end else if (op) begin
      hi = a % b; lo = a / b; e = 1'b0;
    end else begin
      p = {16'h0000, a} * {16'h0000, b};
      hi = p[31:16]; lo = p[15:0]; e = 1'b0;
    end
  endtask

  task automatic run_op(input string name, input logic op, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] ehi, input logic [15:0] elo, input logic ee);
    logic [15:0] phi, plo;
    logic        perr;
    int          n, bad;
    phi = res_hi; plo = res_lo; perr = err;
    start = 1'b1; op_sel = op; a_i = a; b_i = b;
    tick();
    start = 1'b0;
    if (op && b == 16'h0000) begin
      check($sformatf("%s dz busy/done", name), {30'd0, busy, done}, 32'd1);
    end else begin
      check($sformatf("%s accept busy/done", name), {30'd0, busy, done}, 32'd2);
      n = 0; bad = 0;
      while (!done && n < 40) begin
        if (alu_op !== (op ? 4'b0010 : 4'b0000)) bad++;
        if (!busy || res_hi !== phi || res_lo !== plo || err !== perr) bad++;
        tick();
        n++;
      end
      check($sformatf("%s latency", name), n, 32'd16);
      check($sformatf("%s busy-phase violations", name), bad, 32'd0);
      check($sformatf("%s busy at done", name), {31'd0, busy}, 32'd0);
    end
    check($sformatf("%s res_hi", name), {16'd0, res_hi}, {16'd0, ehi});
    check($sformatf("%s res_lo", name), {16'd0, res_lo}, {16'd0, elo});
    check($sformatf("%s err", name), {31'd0, err}, {31'd0, ee});
  endtask

  initial begin
    logic [15:0] ehi, elo, ra, rb;
    logic        ee, rop;
    int          n, pulses;

    vecs[0] = '{1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0};
    vecs[1] = '{1'b0, 16'h1234, 16'h0010, 16'h0001, 16'h2340, 1'b0};
    vecs[2] = '{1'b1, 16'h0064, 16'h0007, 16'h0002, 16'h000E, 1'b0};
    vecs[3] = '{1'b1, 16'hFFFF, 16'h8001, 16'h7FFE, 16'h0001, 1'b0};
    vecs[4] = '{1'b1, 16'h1234, 16'h0000, 16'h1234, 16'hFFFF, 1'b1};
    vecs[5] = '{1'b0, 16'h0000, 16'hABCD, 16'h0000, 16'h0000, 1'b0};
    vecs[6] = '{1'b0, 16'h8000, 16'h0002, 16'h0001, 16'h0000, 1'b0};
    vecs[7] = '{1'b1, 16'h0001, 16'hFFFF, 16'h0001, 16'h0000, 1'b0};
    vecs[8] = '{1'b1, 16'hFFFF, 16'h0001, 16'h0000, 16'hFFFF, 1'b0};
    vecs[9] = '{1'b1, 16'h0005, 16'h0005, 16'h0000, 16'h0001, 1'b0};

    rst = 1'b1; start = 1'b1; op_sel = 1'b0; a_i = 16'h5555; b_i = 16'h3333;
    tick(); tick();
    start = 1'b0;
    check("reset busy/done/err", {29'd0, busy, done, err}, 32'd0);
    check("reset res", {res_hi, res_lo}, 32'd0);
    check("reset alu drive", {11'd0, alu_op, alu_cin, alu_ina}, 32'd0);
    check("reset alu_inb", {16'd0, alu_inb}, 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 10; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].hi, vecs[i].lo, vecs[i].e);

    // back-to-back from the done cycle is exercised above; now a start ignored mid-MUL
    tick();
    start = 1'b1; op_sel = 1'b0; a_i = 16'h0003; b_i = 16'h0005;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    start = 1'b1; op_sel = 1'b1; a_i = 16'h0009; b_i = 16'h0000;
    tick();
    start = 1'b0;
    n = 4;
    check("ignored start no done", {31'd0, done}, 32'd0);
    while (!done && n < 40) begin tick(); n++; end
    check("ignored start latency", n, 32'd16);
    check("ignored start result", {res_hi, res_lo}, 32'h0000000F);
    check("ignored start err", {31'd0, err}, 32'd0);

    // done cycle start: explicit next-cycle busy check
    start = 1'b1; op_sel = 1'b1; a_i = 16'h00FF; b_i = 16'h0010;
    tick();
    start = 1'b0;
    check("b2b busy next cycle", {30'd0, busy, done}, 32'd2);
    n = 0;
    while (!done && n < 40) begin tick(); n++; end
    check("b2b second latency", n, 32'd16);
    check("b2b result", {res_hi, res_lo}, 32'h000F000F);

    // reset at edge 8 of a DIV
    tick();
    start = 1'b1; op_sel = 1'b1; a_i = 16'h1234; b_i = 16'h0003;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid rst busy/done/err", {29'd0, busy, done, err}, 32'd0);
    check("mid rst res", {res_hi, res_lo}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      if (done) pulses++;
      tick();
    end
    check("mid rst no done pulse", pulses, 32'd0);
    run_op("after rst", 1'b1, 16'h1234, 16'h0003, 16'h0001, 16'h0611, 1'b0);

    for (int i = 0; i < 40; i++) begin
      rop = 1'($urandom % 2);
      ra  = 16'($urandom);
      rb  = ($urandom % 4 == 0) ? 16'h0000 : 16'($urandom);
      model(rop, ra, rb, ehi, elo, ee);
      run_op($sformatf("rand%0d op%0d %h %h", i, rop, ra, rb), rop, ra, rb, ehi, elo, ee);
      if ($urandom % 2 == 1) tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
